// File: rtl/sd_load_scheduler.sv
// sd_load_scheduler: round-robin arbiter sharing one SD block loader among NUM_CH sound channels
//   req_i/sel_i            per-channel load request pulse and sound select
//   done_o/err_o           per-channel completion / failure pulses
//   grant_valid_o/grant_ch_o/ch_we_o  current owner and its routed RAM write strobe
//   loader_go_o/loader_sel_o           GO pulse and select toward the loader
//   loader_ram_we_i/loader_done_i/loader_error_i  loader handshake (done/error are levels)
module sd_load_scheduler #(
    parameter int NUM_CH = 4,
    parameter int SEL_W = 5,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd10_000_000
) (
    input  logic                    clk50,
    input  logic                    reset,
    input  logic [NUM_CH-1:0]       req_i,
    input  logic [NUM_CH*SEL_W-1:0] sel_i,
    output logic [NUM_CH-1:0]       done_o,
    output logic [NUM_CH-1:0]       err_o,
    output logic                    grant_valid_o,
    output logic [2:0]              grant_ch_o,
    output logic [NUM_CH-1:0]       ch_we_o,
    output logic                    loader_go_o,
    output logic [SEL_W-1:0]        loader_sel_o,
    input  logic                    loader_ram_we_i,
    input  logic                    loader_done_i,
    input  logic                    loader_error_i
);
    typedef enum logic [2:0] {BOOT, IDLE, ISSUE, WAIT_START, WAIT_DONE, FAULT} state_t;
    state_t state, state_n;
    logic [NUM_CH-1:0] pending, clr, grant_oh, fault_oh;
    logic [SEL_W-1:0] sel_q [NUM_CH];
    logic [SEL_W-1:0] pick_sel;
    logic [2:0] rr_ptr, pick, rr_next;
    logic [23:0] timer;
    logic found, fault_hit, advance, timeout, waiting;
    assign grant_oh = NUM_CH'(1) << grant_ch_o;
    assign rr_next = 3'((int'(grant_ch_o) + 1) % NUM_CH);
    assign timeout = timer == TIMEOUT_CYCLES - 24'd1;
    assign waiting = state == WAIT_START || state == WAIT_DONE;
    assign grant_valid_o = state == ISSUE || waiting;
    assign loader_go_o = state == ISSUE;
    // outer loop walks offsets from rr_ptr so the first hit is the round-robin winner
    always_comb begin
        found = 1'b0;
        pick = '0;
        pick_sel = '0;
        for (int i = 0; i < NUM_CH; i++)
            for (int c = 0; c < NUM_CH; c++)
                if (!found && pending[c] && c == (int'(rr_ptr) + i) % NUM_CH) begin
                    found = 1'b1;
                    pick = 3'(c);
                    pick_sel = sel_q[c];
                end
    end
    always_comb begin
        fault_hit = 1'b0;
        fault_oh = '0;
        for (int c = 0; c < NUM_CH; c++)
            if (!fault_hit && pending[c]) begin
                fault_hit = 1'b1;
                fault_oh[c] = 1'b1;
            end
    end
    always_comb begin
        state_n = state;
        done_o = '0;
        err_o = '0;
        ch_we_o = '0;
        clr = '0;
        advance = 1'b0;
        case (state)
            BOOT: state_n = loader_error_i ? FAULT : loader_done_i ? IDLE : BOOT;
            IDLE: if (found) begin
                clr = NUM_CH'(1) << pick;
                state_n = ISSUE;
            end
            ISSUE: state_n = WAIT_START;
            WAIT_START, WAIT_DONE: begin
                ch_we_o = (state == WAIT_DONE && loader_ram_we_i) ? grant_oh : '0;
                if (loader_error_i) begin
                    err_o = grant_oh;
                    state_n = FAULT;
                end else if (state == WAIT_DONE && loader_done_i) begin
                    done_o = grant_oh;
                    advance = 1'b1;
                    state_n = IDLE;
                end else if (timeout) begin
                    err_o = grant_oh;
                    advance = 1'b1;
                    state_n = IDLE;
                end else if (state == WAIT_START && !loader_done_i) state_n = WAIT_DONE;
            end
            FAULT: begin
                clr = fault_oh;
                err_o = fault_oh;
            end
            default: state_n = BOOT;
        endcase
    end
    always_ff @(posedge clk50) begin
        if (reset) begin
            state <= BOOT;
            pending <= '0;
            rr_ptr <= '0;
            timer <= '0;
            grant_ch_o <= '0;
            loader_sel_o <= '0;
        end else begin
            state <= state_n;
            // a request on the same cycle its bit is cleared re-pends
            pending <= (pending & ~clr) | req_i;
            if (state == IDLE && found) begin
                grant_ch_o <= pick;
                loader_sel_o <= pick_sel;
            end
            if (advance) rr_ptr <= rr_next;
            if (state == ISSUE) timer <= '0;
            else if (waiting && timer != '1) timer <= timer + 24'd1;
        end
    end
    always_ff @(posedge clk50)
        for (int c = 0; c < NUM_CH; c++)
            if (reset) sel_q[c] <= '0;
            else if (req_i[c]) sel_q[c] <= sel_i[c*SEL_W +: SEL_W];
endmodule
